// File: rtl/avmm_mem_bist_master.sv
// rtl/avmm_mem_bist_master.sv - Avalon-MM write/readback self-test master for the on-chip RAM
// Optional macro MEM_BIST_STOP_ON_ERR_EN: stop the run at the first readback mismatch.
module avmm_mem_bist_master #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_FINISH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d, base_q, base_d, ferr_q, ferr_d;
  logic [ADDR_W:0]     count_q, count_d, remain_q, remain_d;
  logic [31:0]         seed_q, seed_d;
  logic [2:0]          lat_q, lat_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [DATA_W-1:0]   cur_pat;
  logic                last_word;
  logic                mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] s, input logic [ADDR_W-1:0] a);
    logic [15:0] a16;
    a16 = 16'(a);
    return DATA_W'(s ^ {~a16, a16});
  endfunction

  assign cur_pat   = pattern(seed_q, cur_q);
  assign last_word = (remain_q == {{ADDR_W{1'b0}}, 1'b1});

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    base_d         = base_q;
    count_d        = count_q;
    remain_d       = remain_q;
    seed_d         = seed_q;
    lat_d          = lat_q;
    err_d          = err_q;
    ferr_d         = ferr_q;
    mismatch       = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_read       = 1'b0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d   = base_addr;
          cur_d    = base_addr;
          count_d  = word_count;
          remain_d = word_count;
          seed_d   = seed;
          err_d    = '0;
          ferr_d   = '0;
          state_d  = (word_count == '0) ? S_FINISH : S_WRITE;
        end
      end
      S_WRITE: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_byteenable = '1;
        avm_writedata  = cur_pat;
        if (!avm_waitrequest) begin
          if (last_word) begin
            cur_d    = base_q;
            remain_d = count_q;
            state_d  = S_RD_REQ;
          end else begin
            cur_d    = cur_q + 1'b1;
            remain_d = remain_q - 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_byteenable = '1;
        if (!avm_waitrequest) begin
          lat_d   = 3'd1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == 3'(READ_LATENCY)) begin
          mismatch = (avm_readdata != cur_pat);
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) ferr_d = cur_q;
          end
`ifdef MEM_BIST_STOP_ON_ERR_EN
          if (mismatch || last_word) begin
`else
          if (last_word) begin
`endif
            state_d = S_FINISH;
          end else begin
            cur_d    = cur_q + 1'b1;
            remain_d = remain_q - 1'b1;
            state_d  = S_RD_REQ;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      // Extra settle cycle so done lands N*(2+READ_LATENCY)+1 edges after start.
      S_FINISH: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      base_q   <= '0;
      count_q  <= '0;
      remain_q <= '0;
      seed_q   <= '0;
      lat_q    <= '0;
      err_q    <= '0;
      ferr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      base_q   <= base_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      seed_q   <= seed_d;
      lat_q    <= lat_d;
      err_q    <= err_d;
      ferr_q   <= ferr_d;
    end
  end

  assign busy           = (state_q == S_WRITE) || (state_q == S_RD_REQ) ||
                          (state_q == S_RD_WAIT) || (state_q == S_FINISH);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign avm_address    = cur_q;

endmodule

// File: tb/tb_avmm_mem_bist_master.sv
// tb/tb_avmm_mem_bist_master.sv - directed self-checking bench for avmm_mem_bist_master
`timescale 1ns/1ps
module tb_avmm_mem_bist_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] word_count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_addr, avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, avm_read, avm_waitrequest;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  avmm_mem_bist_master dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: memory, stall injection, readback corruption and access logs
  logic [31:0] mem [0:65535];
  logic        clr = 1'b0;
  int          stall_wr_idx = -1;
  int          stall_rd_idx = -1;
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;
  int          wr_n, rd_n, cs_cycles, bad, unstable, stall_rem;
  logic        req_started, hold_v, is_target;
  logic [49:0] hold, bus;
  logic [15:0] wr_log[$];
  logic [15:0] rd_log[$];
  logic [31:0] wd_log[$];

  assign bus = {avm_address, avm_writedata, avm_write, avm_read};
  assign is_target = (avm_write && wr_n == stall_wr_idx) || (avm_read && rd_n == stall_rd_idx);
  assign avm_waitrequest = avm_chipselect && (stall_rem != 0 || (!req_started && is_target));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_rem    <= 0;
      req_started  <= 1'b0;
      hold_v       <= 1'b0;
      avm_readdata <= '0;
    end else if (clr) begin
      wr_n <= 0; rd_n <= 0; cs_cycles <= 0; bad <= 0; unstable <= 0;
      wr_log.delete(); rd_log.delete(); wd_log.delete();
    end else if (avm_chipselect) begin
      cs_cycles <= cs_cycles + 1;
      bad <= bad + ((avm_write && avm_read) ? 1 : 0) + ((avm_byteenable != 4'hF) ? 1 : 0);
      if (avm_waitrequest) begin
        req_started <= 1'b1;
        stall_rem   <= req_started ? stall_rem - 1 : 2;
        if (hold_v && bus != hold) unstable <= unstable + 1;
        hold   <= bus;
        hold_v <= 1'b1;
      end else begin
        req_started <= 1'b0;
        hold_v      <= 1'b0;
        if (hold_v && bus != hold) unstable <= unstable + 1;
        if (avm_write) begin
          mem[avm_address] <= avm_writedata;
          wr_log.push_back(avm_address);
          wd_log.push_back(avm_writedata);
          wr_n <= wr_n + 1;
        end else begin
          avm_readdata <= mem[avm_address] ^
                          {31'd0, (corrupt_en && avm_address == corrupt_addr)};
          rd_log.push_back(avm_address);
          rd_n <= rd_n + 1;
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] b, input logic [16:0] n, input logic [31:0] s);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    base_addr = b; word_count = n; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int inject_k, output int edges);
    edges = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == inject_k) begin
        start = 1'b1; base_addr = 16'h0; word_count = 17'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        edges = k;
        break;
      end
    end
    start = 1'b0;
    if (edges < 0) check_eq("run_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] a2, input logic [15:0] a3);
    return {a0, a1, a2, a3};
  endfunction

  int edges;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_status", {61'd0, busy, done, pass}, 64'd0);
    check_eq("rst_err", {32'd0, err_count, first_err_addr}, 64'd0);
    check_eq("rst_avm_ctl", {56'd0, avm_byteenable, avm_chipselect, avm_write, avm_read}, 64'd0);
    check_eq("rst_avm_bus", {16'd0, avm_address, avm_writedata}, 64'd0);
    reset = 1'b0;

    // 1: ideal slave, 4 words at 0x10
    pulse_start(16'h0010, 17'd4, 32'hA5A50000);
    check_eq("t1_busy", {63'd0, busy}, 64'd1);
    wait_done(0, edges);
    check_eq("t1_edges", 64'(edges), 64'd13);
    check_eq("t1_wdata0", {32'd0, wd_log[0]}, 64'h5A4A0010);
    check_eq("t1_wr_order", pack4(wr_log[0], wr_log[1], wr_log[2], wr_log[3]),
             64'h0010_0011_0012_0013);
    check_eq("t1_rd_order", pack4(rd_log[0], rd_log[1], rd_log[2], rd_log[3]),
             64'h0010_0011_0012_0013);
    check_eq("t1_status", {46'd0, pass, busy, err_count}, {46'd0, 1'b1, 1'b0, 16'd0});
    check_eq("t1_bus_rules", 64'(bad), 64'd0);

    // 2: stalls on write 0 and read 1
    stall_wr_idx = 0; stall_rd_idx = 1;
    pulse_start(16'h0010, 17'd4, 32'hA5A50000);
    wait_done(0, edges);
    stall_wr_idx = -1; stall_rd_idx = -1;
    check_eq("t2_edges", 64'(edges), 64'd19);
    check_eq("t2_unstable", 64'(unstable), 64'd0);
    check_eq("t2_counts", {32'(wr_log.size()), 32'(rd_log.size())}, {32'd4, 32'd4});
    check_eq("t2_wr_order", pack4(wr_log[0], wr_log[1], wr_log[2], wr_log[3]),
             64'h0010_0011_0012_0013);
    check_eq("t2_rd_order", pack4(rd_log[0], rd_log[1], rd_log[2], rd_log[3]),
             64'h0010_0011_0012_0013);
    check_eq("t2_pass", {63'd0, pass}, 64'd1);

    // 3: corrupt bit 0 of word 0x12 on readback
    corrupt_en = 1'b1; corrupt_addr = 16'h0012;
    pulse_start(16'h0010, 17'd4, 32'hA5A50000);
    wait_done(0, edges);
    corrupt_en = 1'b0;
    check_eq("t3_err_count", {48'd0, err_count}, 64'd1);
    check_eq("t3_first_err", {48'd0, first_err_addr}, 64'h0012);
    check_eq("t3_pass", {63'd0, pass}, 64'd0);
`ifdef MEM_BIST_STOP_ON_ERR_EN
    check_eq("t3_reads", 64'(rd_log.size()), 64'd3);
`else
    check_eq("t3_reads", 64'(rd_log.size()), 64'd4);
`endif

    // 4: wrap across the top address, with an ignored start mid-run
    pulse_start(16'hFFFE, 17'd4, 32'h1234_5678);
    wait_done(5, edges);
    check_eq("t4_edges", 64'(edges), 64'd13);
    check_eq("t4_wr_order", pack4(wr_log[0], wr_log[1], wr_log[2], wr_log[3]),
             64'hFFFE_FFFF_0000_0001);
    check_eq("t4_rd_order", pack4(rd_log[0], rd_log[1], rd_log[2], rd_log[3]),
             64'hFFFE_FFFF_0000_0001);
    check_eq("t4_wdata2", {32'd0, wd_log[2]}, 64'hEDCB_5678);
    check_eq("t4_pass", {63'd0, pass}, 64'd1);

    // 5: zero-length run
    pulse_start(16'h0040, 17'd0, 32'hDEAD_BEEF);
    wait_done(0, edges);
    check_eq("t5_edges", 64'(edges), 64'd1);
    check_eq("t5_pass", {63'd0, pass}, 64'd1);
    check_eq("t5_cs_cycles", 64'(cs_cycles), 64'd0);

    // 6: asynchronous reset during the write of word 2
    pulse_start(16'h0020, 17'd4, 32'h0F0F_F0F0);
    for (int k = 0; k < 50 && wr_n != 2; k++) begin
      @(posedge clk); #1;
    end
    check_eq("t6_reached_wr2", 64'(wr_n), 64'd2);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_status", {29'd0, busy, done, pass, err_count, first_err_addr},
             64'd0);
    check_eq("t6_rst_avm", {8'd0, avm_chipselect, avm_write, avm_read, avm_byteenable,
                            avm_address, avm_writedata[28:0]}, 64'd0);
    @(negedge clk); reset = 1'b0;
    pulse_start(16'h0020, 17'd4, 32'h0F0F_F0F0);
    wait_done(0, edges);
    check_eq("t6_edges", 64'(edges), 64'd13);
    check_eq("t6_pass", {63'd0, pass}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avmm_mem_bist_master.md
Name: avmm_mem_bist_master

Overview:
- Avalon-MM master that exercises the 32-bit single-port on-chip memory from the initiator side.
- Fills a block of words with an address-derived pattern, reads every word back, and compares each one.
- Sits beside the Nios II data master on the interconnect. Used for board bring-up and lab self-test of the on-chip RAM.
- Software-independent: a start pulse kicks it off, and status is held until the next start.

Parameters:
ADDR_W, 16, word-address width; matches the 65536-word memory.
DATA_W, 32, data width; byteenable width is DATA_W/8.
READ_LATENCY, 1, fixed slave read latency in cycles, 1..4.
ERR_W, 16, width of the saturating error counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle go pulse; ignored while busy=1
base_addr  in  ADDR_W  first word address, sampled on start
word_count  in  ADDR_W+1  number of words to test, sampled on start; 0 allowed
seed  in  32  pattern seed, sampled on start
busy  out  1  high from the cycle after start until done
done  out  1  level; high after a run, cleared by the next accepted start
pass  out  1  valid when done=1; 1 means no mismatches
err_count  out  ERR_W  mismatch count, saturating at all-ones
first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none
avm_address  out  ADDR_W  word address
avm_byteenable  out  DATA_W/8  always all-ones during a transfer
avm_chipselect  out  1  transfer request
avm_write  out  1  write strobe
avm_read  out  1  read strobe
avm_writedata  out  DATA_W  write data
avm_readdata  in  DATA_W  read data
avm_waitrequest  in  1  slave stall

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high.
  - Reset values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
  - All avm_* outputs are 0 in reset, including byteenable.
- Pattern: data(a) = seed XOR {~a[15:0], a[15:0]}, where a is the word address.
- FSM states:
  - IDLE: start sampled → latch inputs, clear status, go to WRITE. If word_count==0, go to DONE instead with pass=1.
  - WRITE: chipselect=1, write=1, address=cur, writedata=data(cur).
    - Hold all of these stable while waitrequest=1.
    - On acceptance (waitrequest=0): increment cur; after the last word, reset cur to base and go to RD_REQ.
  - RD_REQ: chipselect=1, read=1, held stable while waitrequest=1. On acceptance go to RD_WAIT; strobes drop next cycle.
  - RD_WAIT: count READ_LATENCY cycles after acceptance, then sample readdata and compare with data(addr).
    - On mismatch: increment err_count (saturating); the first mismatch also loads first_err_addr.
    - Then advance to the next RD_REQ, or to DONE after the last word.
  - DONE: done=1, busy=0, pass=(err_count==0). Next accepted start goes back through IDLE-start handling.
- Address arithmetic is modulo 2^ADDR_W: a range crossing the top address wraps to 0.
- Byteenable is all-ones; write and read are never asserted together.
- Timing with waitrequest=0 throughout: done rises N*(2+READ_LATENCY)+1 edges after the edge that sampled start, where N=word_count.
- start while busy=1 is ignored; start in DONE begins a new run.
- Reset mid-run aborts immediately: all outputs return to reset values and no partial status is retained.

Optional Feature:
- Macro: MEM_BIST_STOP_ON_ERR_EN.
- Defined: the first mismatch ends the run. FSM goes straight to DONE with err_count=1, pass=0, and no further reads issue.
- Undefined: every word in the range is always checked, and err_count reports the total number of mismatches.

Test Plan:
1. base=0x0010, count=4, seed=0xA5A50000, READ_LATENCY=1, ideal slave model → 4 writes to 0x10..0x13; first word written 0x5A4A0010; done at edge 13; pass=1, err_count=0.
2. Same run, slave asserts waitrequest for 3 cycles on the first write and on the second read → address, data and strobes held stable across the stall; no skipped or duplicated access; pass=1.
3. Slave flips bit 0 of the word at 0x0012 on readback → err_count=1, first_err_addr=0x0012, pass=0. With MEM_BIST_STOP_ON_ERR_EN defined, no read of 0x0013 is issued.
4. base=0xFFFE, count=4 → access order 0xFFFE, 0xFFFF, 0x0000, 0x0001 for both writes and reads; pass=1.
5. count=0 → done=1 and pass=1 on the next edge; chipselect never asserted. A second start during a busy run is ignored.
6. Assert reset during WRITE of word 2 → all outputs 0 asynchronously; a fresh start afterwards completes with pass=1.
